// File: rtl/seg7_scan_reader_pkg.sv
// rtl/seg7_scan_reader_pkg.sv - shared constants and types for the 7-segment scan reader
// Segment bit order is {g,f,e,d,c,b,a}, active-low.

package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_PAT [0:9] = '{
    7'b1000000,
    7'b1111001,
    7'b0100100,
    7'b0110000,
    7'b0011001,
    7'b0010010,
    7'b0000010,
    7'b1111000,
    7'b0000000,
    7'b0010000
  };

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    QUALIFY,
    HOLD
  } state_t;

endpackage

// File: rtl/seg7_scan_reader_if.sv
// rtl/seg7_scan_reader_if.sv - display bus in, recovered frame out
// master drives the observed display lines; slave is the reader.

interface seg7_scan_reader_if #(
  parameter int NUM_DIGITS = 4
);

  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    frame_valid;
  logic                    decode_err;
  logic                    multi_an_err;

  modport master (
    output seg_n,
    output an_n,
    input  digits,
    input  blank,
    input  frame_valid,
    input  decode_err,
    input  multi_an_err
  );

  modport slave (
    input  seg_n,
    input  an_n,
    output digits,
    output blank,
    output frame_valid,
    output decode_err,
    output multi_an_err
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - segment pattern back to a decimal value
// Dark display maps to DIG_BLANK; anything unrecognised maps to DIG_ERR.

module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] value_o,
  output logic       is_blank_o,
  output logic       is_err_o
);

  always_comb begin
    value_o    = DIG_ERR;
    is_blank_o = 1'b0;
    is_err_o   = 1'b1;
    if (pattern_i == SEG_BLANK) begin
      value_o    = DIG_BLANK;
      is_blank_o = 1'b1;
      is_err_o   = 1'b0;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (pattern_i == SEG_PAT[i]) begin
          value_o  = 4'(i);
          is_err_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - recovers digits from a multiplexed active-low 7-segment bus
// Each digit slot must stay stable for STABLE_CYCLES samples before it is captured once.

module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_reader_if.slave  bus
);

  localparam logic [7:0]            STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ONE_N      = NUM_DIGITS'(1);

  logic                    rst_meta_q;
  logic                    rst_q;

  logic [6:0]              seg_s1_q;
  logic [6:0]              seg_s_q;
  logic [6:0]              seg_prev_q;
  logic [NUM_DIGITS-1:0]   an_s1_q;
  logic [NUM_DIGITS-1:0]   an_s_q;
  logic [NUM_DIGITS-1:0]   an_prev_q;

  logic [7:0]              cnt_q;
  logic [7:0]              cnt_d;
  state_t                  state_q;

  logic [4*NUM_DIGITS-1:0] shadow_dig_q;
  logic [NUM_DIGITS-1:0]   shadow_blank_q;
  logic [NUM_DIGITS-1:0]   captured_q;
  logic [NUM_DIGITS-1:0]   captured_d;

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic                    frame_valid_q;
  logic                    decode_err_q;
  logic                    multi_an_err_q;

  logic [NUM_DIGITS-1:0]   an_act;
  logic                    changed;
  logic                    none_act;
  logic                    multi_act;
  logic                    capture;
  logic                    capture_ok;
  logic                    frame_done;

  logic [3:0]              dec_value;
  logic                    dec_blank;
  logic                    dec_err;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

  seg7_pattern_decode u_decode (
    .pattern_i  (seg_s_q),
    .value_o    (dec_value),
    .is_blank_o (dec_blank),
    .is_err_o   (dec_err)
  );

  always_comb begin
    an_act     = ~an_s_q;
    changed    = (seg_s_q != seg_prev_q) || (an_s_q != an_prev_q);
    none_act   = (an_act == '0);
    multi_act  = !none_act && ((an_act & (an_act - ONE_N)) != '0);
    frame_done = &captured_q;

    cnt_d = cnt_q;
    if (changed) begin
      cnt_d = 8'd1;
    end else if (cnt_q < STABLE_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end

    // Capture on the edge where the count reaches its target, not one later.
    capture    = (state_q == QUALIFY) && !changed && !none_act && (cnt_d == STABLE_MAX);
    capture_ok = capture && !multi_act;

    captured_d = frame_done ? '0 : captured_q;
    if (capture_ok) begin
      captured_d = captured_d | an_act;
    end
  end

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      seg_s1_q       <= '0;
      seg_s_q        <= '0;
      seg_prev_q     <= '0;
      an_s1_q        <= '0;
      an_s_q         <= '0;
      an_prev_q      <= '0;
      cnt_q          <= '0;
      state_q        <= IDLE;
      shadow_dig_q   <= '0;
      shadow_blank_q <= '0;
      captured_q     <= '0;
      digits_q       <= '0;
      blank_q        <= '0;
      frame_valid_q  <= 1'b0;
      decode_err_q   <= 1'b0;
      multi_an_err_q <= 1'b0;
    end else begin
      seg_s1_q   <= bus.seg_n;
      seg_s_q    <= seg_s1_q;
      seg_prev_q <= seg_s_q;
      an_s1_q    <= bus.an_n;
      an_s_q     <= an_s1_q;
      an_prev_q  <= an_s_q;
      cnt_q      <= cnt_d;

      case (state_q)
        IDLE: begin
          if (!none_act) state_q <= QUALIFY;
        end
        QUALIFY: begin
          if (none_act)     state_q <= IDLE;
          else if (capture) state_q <= HOLD;
        end
        HOLD: begin
          if (none_act)     state_q <= IDLE;
          else if (changed) state_q <= QUALIFY;
        end
        default: state_q <= IDLE;
      endcase

      decode_err_q   <= capture_ok && dec_err;
      multi_an_err_q <= capture && multi_act;

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture_ok && an_act[i]) begin
          shadow_dig_q[4*i +: 4] <= dec_value;
          shadow_blank_q[i]      <= dec_blank;
        end
      end

      // Frame publishes the shadow as it stood before any same-cycle capture.
      captured_q    <= captured_d;
      frame_valid_q <= frame_done;
      if (frame_done) begin
        digits_q <= shadow_dig_q;
        blank_q  <= shadow_blank_q;
      end
    end
  end

  assign bus.digits       = digits_q;
  assign bus.blank        = blank_q;
  assign bus.frame_valid  = frame_valid_q;
  assign bus.decode_err   = decode_err_q;
  assign bus.multi_an_err = multi_an_err_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb/tb_seg7_scan_reader.sv - directed self-checking bench for seg7_scan_reader

module tb_seg7_scan_reader;

  localparam int ND = 4;
  localparam int SC = 4;

  localparam logic [6:0] P0  = 7'b1000000;
  localparam logic [6:0] P1  = 7'b1111001;
  localparam logic [6:0] P2  = 7'b0100100;
  localparam logic [6:0] P3  = 7'b0110000;
  localparam logic [6:0] P4  = 7'b0011001;
  localparam logic [6:0] P5  = 7'b0010010;
  localparam logic [6:0] P6  = 7'b0000010;
  localparam logic [6:0] P7  = 7'b1111000;
  localparam logic [6:0] P8  = 7'b0000000;
  localparam logic [6:0] P9  = 7'b0010000;
  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] BAD = 7'b0101010;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  seg7_scan_reader_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int fv_cnt = 0;
  int derr_cnt = 0;
  int merr_cnt = 0;

  always @(posedge clk) begin
    #2;
    if (bus.frame_valid === 1'b1)  fv_cnt = fv_cnt + 1;
    if (bus.decode_err === 1'b1)   derr_cnt = derr_cnt + 1;
    if (bus.multi_an_err === 1'b1) merr_cnt = merr_cnt + 1;
  end

  task automatic show(input int idx, input logic [6:0] pat, input int hold);
    logic [ND-1:0] one;
    one = 1;
    bus.an_n  = ~(one << idx);
    bus.seg_n = pat;
    repeat (hold) @(negedge clk);
  endtask

  task automatic go_idle();
    bus.an_n  = '1;
    bus.seg_n = BLK;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.an_n  = '1;
    bus.seg_n = BLK;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.digits !== 16'h0000) $display("FAIL reset_digits got %h exp %h", bus.digits, 16'h0000); else pass_cnt++;
    total_cnt++; if (bus.blank !== 4'b0000) $display("FAIL reset_blank got %b exp %b", bus.blank, 4'b0000); else pass_cnt++;
    total_cnt++; if (bus.frame_valid !== 1'b0) $display("FAIL reset_fv got %b exp 0", bus.frame_valid); else pass_cnt++;
    total_cnt++; if (bus.decode_err !== 1'b0) $display("FAIL reset_derr got %b exp 0", bus.decode_err); else pass_cnt++;
    total_cnt++; if (bus.multi_an_err !== 1'b0) $display("FAIL reset_merr got %b exp 0", bus.multi_an_err); else pass_cnt++;
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_scan();
    int f0, d0, m0;
    f0 = fv_cnt; d0 = derr_cnt; m0 = merr_cnt;
    show(0, P1, 20);
    show(1, P2, 20);
    show(2, P3, 20);
    show(3, P4, 20);
    go_idle();
    total_cnt++; if (fv_cnt - f0 !== 1) $display("FAIL scan_frames got %0d exp 1", fv_cnt - f0); else pass_cnt++;
    total_cnt++; if (bus.digits !== 16'h4321) $display("FAIL scan_digits got %h exp %h", bus.digits, 16'h4321); else pass_cnt++;
    total_cnt++; if (bus.blank !== 4'b0000) $display("FAIL scan_blank got %b exp %b", bus.blank, 4'b0000); else pass_cnt++;
    total_cnt++; if (derr_cnt - d0 !== 0) $display("FAIL scan_derr got %0d exp 0", derr_cnt - d0); else pass_cnt++;
    total_cnt++; if (merr_cnt - m0 !== 0) $display("FAIL scan_merr got %0d exp 0", merr_cnt - m0); else pass_cnt++;
  endtask

  task automatic test_blank();
    int f0, d0;
    f0 = fv_cnt; d0 = derr_cnt;
    show(0, P5, 20);
    show(1, P6, 20);
    show(2, BLK, 20);
    show(3, P8, 20);
    go_idle();
    total_cnt++; if (fv_cnt - f0 !== 1) $display("FAIL blank_frames got %0d exp 1", fv_cnt - f0); else pass_cnt++;
    total_cnt++; if (bus.digits !== 16'h8F65) $display("FAIL blank_digits got %h exp %h", bus.digits, 16'h8F65); else pass_cnt++;
    total_cnt++; if (bus.blank !== 4'b0100) $display("FAIL blank_mask got %b exp %b", bus.blank, 4'b0100); else pass_cnt++;
    total_cnt++; if (derr_cnt - d0 !== 0) $display("FAIL blank_derr got %0d exp 0", derr_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_decode_err();
    int f0, d0;
    f0 = fv_cnt; d0 = derr_cnt;
    show(0, P0, 20);
    show(1, BAD, 20);
    show(2, P7, 20);
    show(3, P9, 20);
    go_idle();
    total_cnt++; if (derr_cnt - d0 !== 1) $display("FAIL derr_pulses got %0d exp 1", derr_cnt - d0); else pass_cnt++;
    total_cnt++; if (fv_cnt - f0 !== 1) $display("FAIL derr_frames got %0d exp 1", fv_cnt - f0); else pass_cnt++;
    total_cnt++; if (bus.digits !== 16'h97E0) $display("FAIL derr_digits got %h exp %h", bus.digits, 16'h97E0); else pass_cnt++;
    total_cnt++; if (bus.blank !== 4'b0000) $display("FAIL derr_blank got %b exp %b", bus.blank, 4'b0000); else pass_cnt++;
  endtask

  task automatic test_multi_an();
    int f0, m0;
    show(0, P3, 20);
    show(1, P5, 20);
    f0 = fv_cnt; m0 = merr_cnt;
    bus.an_n  = 4'b1100;
    bus.seg_n = P8;
    repeat (10) @(negedge clk);
    total_cnt++; if (merr_cnt - m0 !== 1) $display("FAIL multi_pulses got %0d exp 1", merr_cnt - m0); else pass_cnt++;
    total_cnt++; if (fv_cnt - f0 !== 0) $display("FAIL multi_frames got %0d exp 0", fv_cnt - f0); else pass_cnt++;
    show(2, P7, 20);
    show(3, P1, 20);
    go_idle();
    total_cnt++; if (fv_cnt - f0 !== 1) $display("FAIL multi_after_frames got %0d exp 1", fv_cnt - f0); else pass_cnt++;
    total_cnt++; if (bus.digits !== 16'h1753) $display("FAIL multi_digits got %h exp %h", bus.digits, 16'h1753); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int f0, lat, pulses;
    show(1, P1, 20);
    show(2, P2, 20);
    show(3, P3, 20);
    f0 = fv_cnt;
    bus.an_n = 4'b1110;
    for (int k = 0; k < 15; k++) begin
      bus.seg_n = (k % 2 == 0) ? P8 : P0;
      repeat (2) @(negedge clk);
    end
    total_cnt++; if (fv_cnt - f0 !== 0) $display("FAIL glitch_frames got %0d exp 0", fv_cnt - f0); else pass_cnt++;
    bus.seg_n = P9;
    lat = 0;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1) begin
        pulses++;
        if (lat == 0) lat = k;
      end
    end
    total_cnt++; if (lat !== SC + 3) $display("FAIL glitch_latency got %0d exp %0d", lat, SC + 3); else pass_cnt++;
    total_cnt++; if (pulses !== 1) $display("FAIL glitch_pulses got %0d exp 1", pulses); else pass_cnt++;
    total_cnt++; if (bus.digits !== 16'h3219) $display("FAIL glitch_digits got %h exp %h", bus.digits, 16'h3219); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    show(1, P1, 20);
    show(2, P1, 20);
    show(3, P1, 20);
    reset = 1'b1;
    bus.an_n  = '1;
    bus.seg_n = BLK;
    #1;
    total_cnt++; if (bus.digits !== 16'h0000) $display("FAIL midrst_digits got %h exp %h", bus.digits, 16'h0000); else pass_cnt++;
    total_cnt++; if (bus.blank !== 4'b0000) $display("FAIL midrst_blank got %b exp %b", bus.blank, 4'b0000); else pass_cnt++;
    total_cnt++; if (bus.frame_valid !== 1'b0) $display("FAIL midrst_fv got %b exp 0", bus.frame_valid); else pass_cnt++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    f0 = fv_cnt;
    show(0, P6, 20);
    go_idle();
    total_cnt++; if (fv_cnt - f0 !== 0) $display("FAIL midrst_partial got %0d exp 0", fv_cnt - f0); else pass_cnt++;
    show(1, P7, 20);
    show(2, P8, 20);
    show(3, P9, 20);
    go_idle();
    total_cnt++; if (fv_cnt - f0 !== 1) $display("FAIL midrst_frames got %0d exp 1", fv_cnt - f0); else pass_cnt++;
    total_cnt++; if (bus.digits !== 16'h9876) $display("FAIL midrst_digits_new got %h exp %h", bus.digits, 16'h9876); else pass_cnt++;
  endtask

  initial begin
    bus.an_n  = '1;
    bus.seg_n = BLK;
    @(negedge clk);
    test_reset();
    test_scan();
    test_blank();
    test_decode_err();
    test_multi_an();
    test_glitch();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Observes a multiplexed, active-low 7-segment display bus: segment lines plus one enable line per digit.
- Recovers the displayed decimal digits, 4 bits per digit.
- Synchronizes the bus, waits for each digit slot to be stable, decodes the segment pattern back to a number, and assembles a full frame.
- Sits on the board-side capture path and is used for display self-check and loopback verification of the display driver chain.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (1..8)
STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is captured (2..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
seg_n  input  7  segment lines, active-low; bit0=a … bit6=g; asynchronous to clk
an_n  input  NUM_DIGITS  digit enables, active-low; bit i selects digit i; asynchronous to clk
digits  output  4*NUM_DIGITS  last complete frame; nibble i = digit i
blank  output  NUM_DIGITS  bit i set when digit i was dark (seg_n=1111111) in the last frame
frame_valid  output  1  one-cycle pulse when digits/blank update
decode_err  output  1  one-cycle pulse when a stable pattern is not a digit or blank
multi_an_err  output  1  one-cycle pulse on the first stable sample with more than one enable active

Behaviour:
- Reset (async assert, sync deassert internally) drives the following to zero:
  - outputs: digits, blank, frame_valid, decode_err, multi_an_err
  - internal state: synchronizers, stability counter, shadow registers, captured mask
- Synchronizer: seg_n and an_n each pass through 2 flops. All logic below uses the synchronized sample S.
- Stability counter:
  - Increments while S equals the previous cycle's S, saturating at STABLE_CYCLES.
  - Resets to 1 when S changes.
- FSM states:
  - IDLE: no enable active (an all ones). Nothing captured. Go to QUALIFY when any enable is active.
  - QUALIFY: count stability.
    - S changes → stay in QUALIFY, count restarts.
    - Count reaches STABLE_CYCLES → evaluate the sample and go to HOLD.
    - Enables return to all ones → go to IDLE.
  - HOLD: sample already consumed. Any change in S → QUALIFY with count=1; an all ones → IDLE. No re-capture of an unchanged sample.
- Evaluation (single cycle, when entering HOLD):
  - More than one enable low: pulse multi_an_err; nothing captured.
  - Exactly one enable, index i, pattern decoded:
    - Digits 0..9, in order: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
    - Digit value → shadow nibble i = value, shadow blank i = 0, captured[i] = 1.
    - 1111111 → shadow nibble i = 4'hF, shadow blank i = 1, captured[i] = 1.
    - Any other pattern → shadow nibble i = 4'hE, blank i = 0, captured[i] = 1, decode_err pulses.
- Recapturing a digit already in the mask overwrites its shadow entry; the newest value wins.
- Frame completion:
  - On the cycle after captured becomes all ones: digits and blank load from shadow, frame_valid pulses for 1 cycle, and captured clears.
  - A capture arriving in that same cycle is kept in the new mask.
- Latency: from the input becoming stable to the capture edge is STABLE_CYCLES+2 clocks. frame_valid follows 1 clock later.
- Reset mid-frame discards partial captures. digits returns to 0 until the next complete frame.
- Error pulses never coincide with an update of that digit's shadow entry, except for the decode_err case (nibble 4'hE).

Decomposition:
- Package seg7_pkg holds:
  - SEG_PAT[0:9] pattern constants and SEG_BLANK = 7'b1111111
  - DIG_BLANK = 4'hF and DIG_ERR = 4'hE
  - state enum {IDLE, QUALIFY, HOLD}
- One combinational sub-module, seg7_pattern_decode:
  - Input: 7-bit pattern.
  - Outputs: 4-bit value, is_blank, is_err.
  - Exact inverse of the team's digit-to-segment encoder.

Test Plan:
- Scan 4 digits showing 1,2,3,4, each enable held 20 clocks (STABLE_CYCLES=4) → frame_valid pulse; digits = 16'h4321; blank = 0000; no error pulses.
- Digit 2 held at 1111111 → that frame has blank = 0100 and nibble 2 = F.
- Digit 1 pattern 0101010 held stable → decode_err pulses once; nibble 1 = E in the next frame.
- an_n = 1100 held 10 clocks → multi_an_err pulses once; captured mask unchanged; no frame_valid.
- Glitch: seg_n toggles every 2 clocks for 30 clocks on digit 0 → no capture. Then hold 0010000 → capture 9 exactly STABLE_CYCLES+2 clocks after the hold begins.
- Assert reset after 3 of 4 digits captured → all outputs 0 immediately. After release, a fresh full scan → frame_valid with new values only.
